period_match_detector: RTL and testbench

//  Parametrised repeat/periodicity detector for the sample path. Compares each

---
 rtl/period_match_detector_if.sv | 29 ++
 rtl/period_match_detector.sv | 152 +++++++++++++++
 tb/tb_period_match_detector.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/period_match_detector_if.sv
// Sample-path bus for period_match_detector: sample/config inputs and
// registered match/lock status outputs.
interface period_match_detector_if #(
  parameter int unsigned DW    = 8,
  parameter int unsigned LAG_W = 5,
  parameter int unsigned CW    = 8
) ();
  logic             in_valid;
  logic [DW-1:0]    data_in;
  logic [LAG_W-1:0] lag;
  logic [DW-1:0]    mask;
  logic [CW-1:0]    lock_thr;
  logic [CW-1:0]    unlock_thr;
  logic             match_valid;
  logic             match;
  logic             locked;
  logic [CW-1:0]    run_len;
  logic             cfg_err;

  modport master (
    output in_valid, data_in, lag, mask, lock_thr, unlock_thr,
    input  match_valid, match, locked, run_len, cfg_err
  );

  modport slave (
    input  in_valid, data_in, lag, mask, lock_thr, unlock_thr,
    output match_valid, match, locked, run_len, cfg_err
  );
endinterface

// File: rtl/period_match_detector.sv
// Periodicity detector: compares each accepted sample with the one LAG samples
// earlier under a mask, and qualifies the hits with a lock/hold FSM.
module period_match_detector #(
  parameter int unsigned DW      = 8,
  parameter int unsigned MAX_LAG = 16,
  parameter int unsigned LAG_W   = 5,
  parameter int unsigned CW      = 8
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic                   clr,
  period_match_detector_if.slave bus
);
  localparam int unsigned FW = $clog2(MAX_LAG + 1);

  typedef enum logic [1:0] {StSearch, StLocked, StHold} state_e;

  state_e           state_q, state_d, state_base;
  logic [DW-1:0]    hist_q [MAX_LAG];
  logic [FW-1:0]    fill_q, fill_d;
  logic [LAG_W-1:0] lag_q, lag_d;
  logic [CW-1:0]    run_q, run_d, run_base, run_nxt;
  logic [CW-1:0]    miss_q, miss_d, miss_base;
  logic [CW:0]      miss_inc;
  logic [CW-1:0]    lock_eff, unlock_eff;
  logic             mv_q, mv_d, match_q, match_d, cfg_err_q, cfg_err_d;
  logic             lag_ok, lag_chg, cmp, hit;
  logic [DW-1:0]    ref_smp;

  always_comb begin
    ref_smp = '0;
    for (int i = 0; i < int'(MAX_LAG); i++) begin
      if (bus.lag == LAG_W'(i + 1)) ref_smp = hist_q[i];
    end
  end

  assign lag_ok     = (bus.lag != '0) && (32'(bus.lag) <= MAX_LAG);
  assign lag_chg    = bus.in_valid && lag_ok && (bus.lag != lag_q);
  assign cmp        = bus.in_valid && lag_ok && (32'(fill_q) >= 32'(bus.lag));
  assign hit        = ((bus.data_in ^ ref_smp) & bus.mask) == '0;
  assign lock_eff   = (bus.lock_thr == '0) ? CW'(1) : bus.lock_thr;
  assign unlock_eff = (bus.unlock_thr == '0) ? CW'(1) : bus.unlock_thr;

  always_comb begin
    state_base = state_q;
    run_base   = run_q;
    miss_base  = miss_q;
    lag_d      = lag_q;
    fill_d     = fill_q;
    cfg_err_d  = cfg_err_q;
    mv_d       = 1'b0;
    match_d    = 1'b0;

    // A new legal lag restarts qualification before this cycle's compare.
    if (lag_chg) begin
      state_base = StSearch;
      run_base   = '0;
      miss_base  = '0;
      lag_d      = bus.lag;
    end

    state_d  = state_base;
    run_d    = run_base;
    miss_d   = miss_base;
    run_nxt  = hit ? ((&run_base) ? run_base : run_base + CW'(1)) : '0;
    miss_inc = {1'b0, miss_base} + {{CW{1'b0}}, 1'b1};

    if (bus.in_valid) begin
      cfg_err_d = !lag_ok;
      if (32'(fill_q) < MAX_LAG) fill_d = fill_q + FW'(1);
    end

    if (cmp) begin
      mv_d    = 1'b1;
      match_d = hit;
      run_d   = run_nxt;
      unique case (state_base)
        StSearch: if (run_nxt >= lock_eff) state_d = StLocked;
        StLocked: begin
          if (!hit) begin
            if (unlock_eff == CW'(1)) begin
              state_d = StSearch;
              miss_d  = '0;
            end else begin
              state_d = StHold;
              miss_d  = CW'(1);
            end
          end
        end
        StHold: begin
          if (hit) begin
            state_d = StLocked;
            miss_d  = '0;
          end else if (miss_inc >= {1'b0, unlock_eff}) begin
            state_d = StSearch;
            miss_d  = '0;
          end else begin
            miss_d  = miss_inc[CW-1:0];
          end
        end
        default: state_d = StSearch;
      endcase
    end

    if (clr) begin
      state_d   = StSearch;
      run_d     = '0;
      miss_d    = '0;
      lag_d     = '0;
      fill_d    = '0;
      cfg_err_d = 1'b0;
      mv_d      = 1'b0;
      match_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StSearch;
      run_q     <= '0;
      miss_q    <= '0;
      lag_q     <= '0;
      fill_q    <= '0;
      cfg_err_q <= 1'b0;
      mv_q      <= 1'b0;
      match_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      run_q     <= run_d;
      miss_q    <= miss_d;
      lag_q     <= lag_d;
      fill_q    <= fill_d;
      cfg_err_q <= cfg_err_d;
      mv_q      <= mv_d;
      match_q   <= match_d;
    end
  end

  // History contents are don't-care after reset; fill gates their use.
  always_ff @(posedge clk) begin
    if (bus.in_valid && !clr) begin
      hist_q[0] <= bus.data_in;
      for (int i = 1; i < int'(MAX_LAG); i++) hist_q[i] <= hist_q[i-1];
    end
  end

  assign bus.match_valid = mv_q;
  assign bus.match       = match_q;
  assign bus.locked      = (state_q != StSearch);
  assign bus.run_len     = run_q;
  assign bus.cfg_err     = cfg_err_q;
endmodule

// File: tb/tb_period_match_detector.sv
// Self-checking bench for period_match_detector: vector tables plus hand-written
// corner sequences, with expectations queued at drive time and checked on output.
module tb_period_match_detector;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;

  period_match_detector_if #(.DW(8), .LAG_W(5), .CW(8)) bus ();

  period_match_detector #(.DW(8), .MAX_LAG(16), .LAG_W(5), .CW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mv;
    logic       m;
    logic       lk;
    logic [7:0] rl;
    logic       ce;
  } exp_t;

  typedef struct {
    logic [7:0] d;
    logic       mv;
    logic       m;
    logic       lk;
    logic [7:0] rl;
  } vec_t;

  exp_t sb[$];
  exp_t cur;
  int   total = 0;
  int   bad = 0;
  vec_t t1[8];
  vec_t t4[4];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(logic mv, logic m, logic lk, logic [7:0] rl, logic ce);
    exp_t e;
    e.mv = mv; e.m = m; e.lk = lk; e.rl = rl; e.ce = ce;
    return e;
  endfunction

  // One clock of stimulus; the expectation applies to outputs after that edge.
  task automatic step(input logic v, input logic c, input logic [7:0] d, input exp_t e);
    bus.in_valid = v;
    clr          = c;
    bus.data_in  = d;
    @(posedge clk);
    #1;
    sb.push_back(e);
    bus.in_valid = 1'b0;
    clr          = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mv"}, 8'(bus.match_valid), 8'd0);
    chk({tag, "_m"}, 8'(bus.match), 8'd0);
    chk({tag, "_lk"}, 8'(bus.locked), 8'd0);
    chk({tag, "_rl"}, bus.run_len, 8'd0);
    chk({tag, "_ce"}, 8'(bus.cfg_err), 8'd0);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      chk("match_valid", 8'(bus.match_valid), 8'(cur.mv));
      if (cur.mv) chk("match", 8'(bus.match), 8'(cur.m));
      chk("locked", 8'(bus.locked), 8'(cur.lk));
      chk("run_len", bus.run_len, cur.rl);
      chk("cfg_err", 8'(bus.cfg_err), 8'(cur.ce));
    end
  end

  initial begin
    logic       plk;
    logic [7:0] prl;

    t1[0] = '{8'h11, 1'b0, 1'b0, 1'b0, 8'd0};
    t1[1] = '{8'h22, 1'b0, 1'b0, 1'b0, 8'd0};
    t1[2] = '{8'h33, 1'b0, 1'b0, 1'b0, 8'd0};
    t1[3] = '{8'h44, 1'b0, 1'b0, 1'b0, 8'd0};
    t1[4] = '{8'h11, 1'b1, 1'b1, 1'b0, 8'd1};
    t1[5] = '{8'h22, 1'b1, 1'b1, 1'b0, 8'd2};
    t1[6] = '{8'h33, 1'b1, 1'b1, 1'b1, 8'd3};
    t1[7] = '{8'h44, 1'b1, 1'b1, 1'b1, 8'd4};
    // Continues after t1: miss (hold), hit (relock), miss, miss (drop).
    t4[0] = '{8'h55, 1'b1, 1'b0, 1'b1, 8'd0};
    t4[1] = '{8'h22, 1'b1, 1'b1, 1'b1, 8'd1};
    t4[2] = '{8'h66, 1'b1, 1'b0, 1'b1, 8'd0};
    t4[3] = '{8'h77, 1'b1, 1'b0, 1'b0, 8'd0};

    bus.in_valid   = 1'b0;
    bus.data_in    = '0;
    bus.lag        = 5'd4;
    bus.mask       = 8'hFF;
    bus.lock_thr   = 8'd3;
    bus.unlock_thr = 8'd2;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all_zero("reset");

    // T1 + T4: back-to-back stream, then miss-tolerant hold behaviour.
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, t1[i].d, mk(t1[i].mv, t1[i].m, t1[i].lk, t1[i].rl, 1'b0));
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b0, t4[i].d, mk(t4[i].mv, t4[i].m, t4[i].lk, t4[i].rl, 1'b0));

    // T2: clr with a simultaneous sample, then the T1 stream with idle gaps.
    step(1'b1, 1'b1, 8'h99, mk(1'b0, 1'b0, 1'b0, 8'd0, 1'b0));
    plk = 1'b0;
    prl = 8'd0;
    for (int i = 0; i < 8; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++)
        step(1'b0, 1'b0, 8'h5A, mk(1'b0, 1'b0, plk, prl, 1'b0));
      step(1'b1, 1'b0, t1[i].d, mk(t1[i].mv, t1[i].m, t1[i].lk, t1[i].rl, 1'b0));
      plk = t1[i].lk;
      prl = t1[i].rl;
    end

    // T5: illegal lags flag cfg_err and hold state; a lag change restarts lock.
    bus.lag = 5'd0;
    step(1'b1, 1'b0, 8'h5A, mk(1'b0, 1'b0, 1'b1, 8'd4, 1'b1));
    bus.lag = 5'd3;
    step(1'b1, 1'b0, 8'h33, mk(1'b1, 1'b1, 1'b0, 8'd1, 1'b0));
    bus.lag = 5'd17;
    step(1'b1, 1'b0, 8'h44, mk(1'b0, 1'b0, 1'b0, 8'd1, 1'b1));

    // T3: partial mask, then full mask.
    bus.lag  = 5'd1;
    bus.mask = 8'hF0;
    step(1'b1, 1'b0, 8'hA1, mk(1'b1, 1'b0, 1'b0, 8'd0, 1'b0));
    step(1'b1, 1'b0, 8'hA7, mk(1'b1, 1'b1, 1'b0, 8'd1, 1'b0));
    step(1'b1, 1'b0, 8'hAF, mk(1'b1, 1'b1, 1'b0, 8'd2, 1'b0));
    bus.mask = 8'hFF;
    step(1'b1, 1'b0, 8'hA3, mk(1'b1, 1'b0, 1'b0, 8'd0, 1'b0));

    // mask=0 always hits; lock_thr=0 acts as 1; run_len saturates at 255.
    bus.mask     = 8'h00;
    bus.lock_thr = 8'd0;
    for (int n = 1; n <= 300; n++)
      step(1'b1, 1'b0, 8'($urandom), mk(1'b1, 1'b1, 1'b1, (n < 255) ? 8'(n) : 8'd255, 1'b0));

    // T6: clr while locked, then refill with lag=4.
    bus.lag      = 5'd4;
    bus.mask     = 8'hFF;
    bus.lock_thr = 8'd3;
    step(1'b0, 1'b1, 8'h00, mk(1'b0, 1'b0, 1'b0, 8'd0, 1'b0));
    for (int i = 0; i < 8; i++)
      step(1'b1, 1'b0, t1[i].d, mk(t1[i].mv, t1[i].m, t1[i].lk, t1[i].rl, 1'b0));

    // Asynchronous reset mid-stream while locked.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b0, t1[i].d, mk(t1[i].mv, t1[i].m, t1[i].lk, t1[i].rl, 1'b0));

    @(negedge clk);
    #1;
    chk("sb_drained", 8'(sb.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
